// File: rtl/rst_sync_seq.sv
// Reset synchroniser and sequencer: syncs RST deassertion, holds MIN_ASSERT cycles, releases NUM_CH resets in ascending order.
// Latency: channel i releases NUM_STAGES + MIN_ASSERT + i*GAP_CYCLES edges after RST rises (or MIN_ASSERT after last SW_RST_REQ).
// Backpressure: none; SW_RST_REQ restarts the sequence at any time once the synchroniser has released, RST clears asynchronously.
module rst_sync_seq #(
  parameter int    NUM_STAGES = 2,
  parameter int    NUM_CH     = 4,
  parameter int    MIN_ASSERT = 8,
  parameter int    GAP_CYCLES = 4,
  parameter string ACTIVE_TYP = "LOW"
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
);

  localparam int CNT_MAX = (MIN_ASSERT > GAP_CYCLES) ? MIN_ASSERT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int CHW     = $clog2(NUM_CH + 1);

  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam bit ACT_LOW = (ACTIVE_TYP == "LOW");
  // With no gap or a single channel everything releases on the HOLD exit edge.
  localparam bit FAST    = (GAP_CYCLES == 0) || (NUM_CH == 1);

  localparam logic [NUM_CH-1:0] ALL_ASSERTED = ACT_LOW ? {NUM_CH{1'b0}} : {NUM_CH{1'b1}};
  localparam logic [NUM_CH-1:0] ALL_RELEASED = ~ALL_ASSERTED;

  // Reject illegal configurations at elaboration.
  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("rst_sync_seq: NUM_STAGES must be >= 2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("rst_sync_seq: NUM_CH must be in 1..16");
  end
  if (MIN_ASSERT < 1) begin : g_bad_min
    $error("rst_sync_seq: MIN_ASSERT must be >= 1");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("rst_sync_seq: GAP_CYCLES must be >= 0");
  end
  if (!(ACTIVE_TYP == "LOW" || ACTIVE_TYP == "HIGH")) begin : g_bad_pol
    $error("rst_sync_seq: ACTIVE_TYP must be \"LOW\" or \"HIGH\"");
  end

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  logic [NUM_STAGES-1:0] sync_q;
  logic                  rst_ok;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CHW-1:0]        n_rel;

  // Output level with the lowest n channels released, the rest asserted.
  function automatic logic [NUM_CH-1:0] drive_lvl(input logic [CHW-1:0] n);
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CHW'(i) < n) m[i] = 1'b1;
    end
    return ACT_LOW ? m : ~m;
  endfunction

  // Synchroniser: assertion is asynchronous, deassertion ripples a 1 through the chain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
  end

  assign rst_ok = sync_q[NUM_STAGES-1];

  // Sequencer FSM: hold, release channels one by one, then run; outputs are registered here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_HOLD;
      cnt      <= '0;
      n_rel    <= '0;
      SYNC_RST <= ALL_ASSERTED;
      RST_DONE <= 1'b0;
    end else if (rst_ok && SW_RST_REQ) begin
      // Software request re-asserts everything and restarts the hold count.
      state    <= S_HOLD;
      cnt      <= '0;
      n_rel    <= '0;
      SYNC_RST <= ALL_ASSERTED;
      RST_DONE <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (rst_ok) begin
            if (cnt == MIN_LAST) begin
              cnt <= '0;
              if (FAST) begin
                state    <= S_RUN;
                n_rel    <= CHW'(NUM_CH);
                SYNC_RST <= ALL_RELEASED;
                RST_DONE <= 1'b1;
              end else begin
                state    <= S_RELEASE;
                n_rel    <= CHW'(1);
                SYNC_RST <= drive_lvl(CHW'(1));
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            n_rel    <= n_rel + 1'b1;
            SYNC_RST <= drive_lvl(n_rel + 1'b1);
            if (n_rel == CHW'(NUM_CH - 1)) begin
              state    <= S_RUN;
              RST_DONE <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule
